// File: rtl/tfm_pipe.sv
// Pipelined complex twiddle multiplier with FFT/IFFT conjugation, rounding,
// optional saturation (sticky flag), valid/ready backpressure and a last tag.
module tfm_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int ROM_WIDTH   = 18,
  parameter int FRAC_BITS   = 16,
  parameter int PIPE_STAGES = 3,
  parameter int ROUND_MODE  = 1,
  parameter int SATURATE    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] data_re,
  input  logic signed [DATA_WIDTH-1:0] data_im,
  input  logic signed [ROM_WIDTH-1:0]  cos_theta,
  input  logic signed [ROM_WIDTH-1:0]  sin_theta,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im,
  output logic                         sat_flag,
  input  logic                         sat_clr
);

  localparam int PW = DATA_WIDTH + ROM_WIDTH;
  localparam int SW = PW + 1;
  localparam int XW = SW + 1;
  // Stage 2 plus the plain delay stages that sit between it and the output.
  localparam int ND = PIPE_STAGES - 2;

  localparam logic signed [XW-1:0] RND =
    (ROUND_MODE != 0) ? (XW'(1) <<< (FRAC_BITS - 1)) : '0;
  localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic signed [PW-1:0] p_ac, p_bs, p_bc, p_as;
  logic                 s1_valid, s1_last, s1_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_ac     <= '0;
      p_bs     <= '0;
      p_bc     <= '0;
      p_as     <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (adv) begin
      p_ac     <= PW'(data_re) * PW'(cos_theta);
      p_bs     <= PW'(data_im) * PW'(sin_theta);
      p_bc     <= PW'(data_im) * PW'(cos_theta);
      p_as     <= PW'(data_re) * PW'(sin_theta);
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_mode  <= mode;
    end
  end

  // IFFT uses the conjugate twiddle, which flips the sign of the sine terms.
  logic signed [SW-1:0] sum_re, sum_im;
  assign sum_re = s1_mode ? (SW'(p_ac) - SW'(p_bs)) : (SW'(p_ac) + SW'(p_bs));
  assign sum_im = s1_mode ? (SW'(p_bc) + SW'(p_as)) : (SW'(p_bc) - SW'(p_as));

  logic signed [SW-1:0] d_re [ND];
  logic signed [SW-1:0] d_im [ND];
  logic                 d_valid [ND];
  logic                 d_last  [ND];

  for (genvar gi = 0; gi < ND; gi++) begin : g_dly
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d_re[gi]    <= '0;
        d_im[gi]    <= '0;
        d_valid[gi] <= 1'b0;
        d_last[gi]  <= 1'b0;
      end else if (adv) begin
        if (gi == 0) begin
          d_re[gi]    <= sum_re;
          d_im[gi]    <= sum_im;
          d_valid[gi] <= s1_valid;
          d_last[gi]  <= s1_last;
        end else begin
          d_re[gi]    <= d_re[gi-1];
          d_im[gi]    <= d_im[gi-1];
          d_valid[gi] <= d_valid[gi-1];
          d_last[gi]  <= d_last[gi-1];
        end
      end
    end
  end

  // Returns {saturated, value}; overflow shows up as non-uniform bits above the sign bit.
  function automatic logic [DATA_WIDTH:0] scale(input logic signed [SW-1:0] sum);
    logic signed [XW-1:0] t;
    logic                 hi_zero, hi_ones;
    t       = (XW'(sum) + RND) >>> FRAC_BITS;
    hi_zero = ~|t[XW-1:DATA_WIDTH-1];
    hi_ones = &t[XW-1:DATA_WIDTH-1];
    if (SATURATE != 0 && !(hi_zero || hi_ones))
      return {1'b1, (t[XW-1] ? MINV : MAXV)};
    return {1'b0, t[DATA_WIDTH-1:0]};
  endfunction

  logic [DATA_WIDTH:0] sc_re, sc_im;
  assign sc_re = scale(d_re[ND-1]);
  assign sc_im = scale(d_im[ND-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= d_valid[ND-1];
        if (d_valid[ND-1]) begin
          out_re   <= sc_re[DATA_WIDTH-1:0];
          out_im   <= sc_im[DATA_WIDTH-1:0];
          out_last <= d_last[ND-1];
        end
      end
      if (adv && d_valid[ND-1] && (sc_re[DATA_WIDTH] || sc_im[DATA_WIDTH]))
        sat_flag <= 1'b1;
      else if (sat_clr)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tfm_pipe.sv
// Bench for tfm_pipe: two instances (3-stage/round/saturate and 5-stage/floor/wrap)
// checked by directed cases and a randomized backpressure stream against a math model.
module tb_tfm_pipe;
  localparam int DW = 16;
  localparam int RW = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic mode = 1'b0, in_last = 1'b0, sat_clr = 1'b0;
  logic signed [DW-1:0] data_re = '0, data_im = '0;
  logic signed [RW-1:0] cos_theta = '0, sin_theta = '0;
  logic in_valid [2], out_ready [2], in_ready [2], out_valid [2], out_last [2], sat_flag [2];
  logic signed [DW-1:0] out_re [2], out_im [2];

  int total = 0;
  int bad = 0;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 last;
    bit                   sat;
  } exp_t;

  tfm_pipe #(.PIPE_STAGES(3), .ROUND_MODE(1), .SATURATE(1)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_last(in_last), .data_re(data_re), .data_im(data_im), .cos_theta(cos_theta),
    .sin_theta(sin_theta), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .out_re(out_re[0]), .out_im(out_im[0]),
    .sat_flag(sat_flag[0]), .sat_clr(sat_clr));

  tfm_pipe #(.PIPE_STAGES(5), .ROUND_MODE(0), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_last(in_last), .data_re(data_re), .data_im(data_im), .cos_theta(cos_theta),
    .sin_theta(sin_theta), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .out_re(out_re[1]), .out_im(out_im[1]),
    .sat_flag(sat_flag[1]), .sat_clr(sat_clr));

  // Instance 0 rounds half up and saturates; instance 1 floors and wraps.
  function automatic logic signed [DW-1:0] scale_ref(input longint sum, input bit rnd_on,
                                                     input bit sat_on, output bit sat);
    longint v;
    v = (sum + (rnd_on ? 64'sd32768 : 64'sd0)) >>> 16;
    sat = 1'b0;
    if (sat_on && v > 32767) begin sat = 1'b1; return 16'sh7fff; end
    if (sat_on && v < -32768) begin sat = 1'b1; return 16'sh8000; end
    return v[15:0];
  endfunction

  function automatic exp_t ref_model(input int k, input longint a, input longint b,
                                     input longint c, input longint s, input logic m,
                                     input logic l);
    longint sr, si;
    bit s1, s2;
    exp_t e;
    sr = m ? (a * c - b * s) : (a * c + b * s);
    si = m ? (b * c + a * s) : (b * c - a * s);
    e.re   = scale_ref(sr, k == 0, k == 0, s1);
    e.im   = scale_ref(si, k == 0, k == 0, s2);
    e.sat  = s1 | s2;
    e.last = l;
    return e;
  endfunction

  // Drives one sample into instance k with out_ready high and reports the result and latency.
  task automatic send_one(input int k, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                          input logic signed [RW-1:0] c, input logic signed [RW-1:0] s,
                          input logic m, output logic signed [DW-1:0] re,
                          output logic signed [DW-1:0] im, output int lat);
    @(negedge clk);
    data_re = a; data_im = b; cos_theta = c; sin_theta = s; mode = m; in_last = 1'b0;
    in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      lat++;
    end while (!out_valid[k] && lat < 40);
    re = out_re[k];
    im = out_im[k];
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid[k] !== 1'b0 || out_re[k] !== 16'sd0 || out_im[k] !== 16'sd0 ||
          out_last[k] !== 1'b0 || sat_flag[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset_state inst=%0d: valid=%b re=%0d im=%0d last=%b sat=%b rdy=%b, want 0 0 0 0 0 1",
                 k, out_valid[k], out_re[k], out_im[k], out_last[k], sat_flag[k], in_ready[k]);
      end
    end
  endtask

  task automatic test_identity(input int k, input int want_lat);
    logic signed [DW-1:0] re, im;
    int lat;
    send_one(k, 16'sd1000, -16'sd2000, 18'sd65536, 18'sd0, 1'b0, re, im, lat);
    $display("txn identity inst=%0d re=%0d im=%0d lat=%0d", k, re, im, lat);
    total++;
    if (lat != want_lat) begin
      bad++;
      $display("FAIL identity_latency inst=%0d: got %0d want %0d", k, lat, want_lat);
    end
    total++;
    if (re !== 16'sd1000 || im !== -16'sd2000 || sat_flag[k] !== 1'b0) begin
      bad++;
      $display("FAIL identity_value inst=%0d: got (%0d,%0d) sat=%b want (1000,-2000) sat=0",
               k, re, im, sat_flag[k]);
    end
  endtask

  task automatic test_mode();
    logic signed [DW-1:0] re, im;
    int lat;
    send_one(0, 16'sd1000, 16'sd500, 18'sd0, 18'sd65536, 1'b0, re, im, lat);
    total++;
    if (re !== 16'sd500 || im !== -16'sd1000) begin
      bad++;
      $display("FAIL mode_fft: got (%0d,%0d) want (500,-1000)", re, im);
    end
    send_one(0, 16'sd1000, 16'sd500, 18'sd0, 18'sd65536, 1'b1, re, im, lat);
    total++;
    if (re !== -16'sd500 || im !== 16'sd1000) begin
      bad++;
      $display("FAIL mode_ifft: got (%0d,%0d) want (-500,1000)", re, im);
    end
    // Back-to-back FFT then IFFT on consecutive cycles.
    @(negedge clk);
    mode = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    mode = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    for (int i = 0; i < 20 && !out_valid[0]; i++) begin
      @(posedge clk); #1;
    end
    $display("txn mode_b2b first re=%0d im=%0d", out_re[0], out_im[0]);
    total++;
    if (out_valid[0] !== 1'b1 || out_re[0] !== 16'sd500 || out_im[0] !== -16'sd1000) begin
      bad++;
      $display("FAIL mode_b2b_first: got v=%b (%0d,%0d) want v=1 (500,-1000)",
               out_valid[0], out_re[0], out_im[0]);
    end
    @(posedge clk); #1;
    $display("txn mode_b2b second re=%0d im=%0d", out_re[0], out_im[0]);
    total++;
    if (out_valid[0] !== 1'b1 || out_re[0] !== -16'sd500 || out_im[0] !== 16'sd1000) begin
      bad++;
      $display("FAIL mode_b2b_second: got v=%b (%0d,%0d) want v=1 (-500,1000)",
               out_valid[0], out_re[0], out_im[0]);
    end
  endtask

  task automatic test_rounding();
    logic signed [DW-1:0] re, im;
    int lat;
    logic signed [DW-1:0] want_pos [2];
    logic signed [DW-1:0] want_neg [2];
    want_pos[0] = 16'sd2;  want_pos[1] = 16'sd1;
    want_neg[0] = -16'sd1; want_neg[1] = -16'sd2;
    for (int k = 0; k < 2; k++) begin
      send_one(k, 16'sd3, 16'sd0, 18'sd32768, 18'sd0, 1'b0, re, im, lat);
      total++;
      if (re !== want_pos[k]) begin
        bad++;
        $display("FAIL round_pos inst=%0d: got %0d want %0d", k, re, want_pos[k]);
      end
      send_one(k, -16'sd3, 16'sd0, 18'sd32768, 18'sd0, 1'b0, re, im, lat);
      total++;
      if (re !== want_neg[k]) begin
        bad++;
        $display("FAIL round_neg inst=%0d: got %0d want %0d", k, re, want_neg[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] re, im;
    int lat;
    send_one(0, -16'sd32768, 16'sd0, -18'sd65536, 18'sd0, 1'b0, re, im, lat);
    total++;
    if (re !== 16'sd32767 || sat_flag[0] !== 1'b1) begin
      bad++;
      $display("FAIL sat_clamp: got re=%0d flag=%b want re=32767 flag=1", re, sat_flag[0]);
    end
    @(negedge clk); sat_clr = 1'b1;
    @(posedge clk); #1; sat_clr = 1'b0;
    total++;
    if (sat_flag[0] !== 1'b0) begin
      bad++;
      $display("FAIL sat_clear: got flag=%b want 0", sat_flag[0]);
    end
    // Clear held high across the load of a saturating sample: set must win.
    sat_clr = 1'b1;
    send_one(0, -16'sd32768, 16'sd0, -18'sd65536, 18'sd0, 1'b0, re, im, lat);
    sat_clr = 1'b0;
    total++;
    if (sat_flag[0] !== 1'b1) begin
      bad++;
      $display("FAIL sat_set_wins: got flag=%b want 1", sat_flag[0]);
    end
    send_one(1, -16'sd32768, 16'sd0, -18'sd65536, 18'sd0, 1'b0, re, im, lat);
    total++;
    if (re !== -16'sd32768 || sat_flag[1] !== 1'b0) begin
      bad++;
      $display("FAIL sat_wrap: got re=%0d flag=%b want re=-32768 flag=0", re, sat_flag[1]);
    end
  endtask

  task automatic test_backpressure(input int k);
    logic signed [DW-1:0] sa [8], sb [8];
    logic signed [RW-1:0] sc [8], ss [8];
    logic sm [8];
    exp_t q [$];
    exp_t e;
    int idx, got, cycles;
    bit prev_stall, any_sat;
    logic signed [DW-1:0] h_re, h_im;
    logic h_last;
    for (int i = 0; i < 8; i++) begin
      sa[i] = DW'($urandom());
      sb[i] = DW'($urandom());
      sc[i] = RW'(int'($urandom_range(0, 131072)) - 65536);
      ss[i] = RW'(int'($urandom_range(0, 131072)) - 65536);
      sm[i] = 1'($urandom());
    end
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    idx = 0; got = 0; cycles = 0; prev_stall = 1'b0; any_sat = 1'b0;
    h_re = '0; h_im = '0; h_last = 1'b0;
    while (got < 8 && cycles < 500) begin
      if (prev_stall) begin
        total++;
        if (out_valid[k] !== 1'b1 || out_re[k] !== h_re || out_im[k] !== h_im ||
            out_last[k] !== h_last) begin
          bad++;
          $display("FAIL stall_hold inst=%0d: got v=%b (%0d,%0d,%b) want v=1 (%0d,%0d,%b)",
                   k, out_valid[k], out_re[k], out_im[k], out_last[k], h_re, h_im, h_last);
        end
      end
      out_ready[k] = ($urandom_range(0, 2) != 0);
      if (idx < 8) begin
        data_re = sa[idx]; data_im = sb[idx]; cos_theta = sc[idx]; sin_theta = ss[idx];
        mode = sm[idx]; in_last = (idx == 7);
        in_valid[k] = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid[k] = 1'b0;
      end
      #1;
      total++;
      if (in_ready[k] !== !(out_valid[k] && !out_ready[k])) begin
        bad++;
        $display("FAIL in_ready_rule inst=%0d: got %b with out_valid=%b out_ready=%b",
                 k, in_ready[k], out_valid[k], out_ready[k]);
      end
      if (out_valid[k] && out_ready[k]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra inst=%0d: got (%0d,%0d) want nothing", k, out_re[k], out_im[k]);
        end else begin
          e = q.pop_front();
          any_sat |= e.sat;
          $display("txn stream inst=%0d #%0d re=%0d im=%0d last=%b", k, got, out_re[k], out_im[k], out_last[k]);
          if (out_re[k] !== e.re || out_im[k] !== e.im || out_last[k] !== e.last) begin
            bad++;
            $display("FAIL stream_data inst=%0d #%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                     k, got, out_re[k], out_im[k], out_last[k], e.re, e.im, e.last);
          end
        end
        got++;
      end
      if (in_valid[k] && in_ready[k]) begin
        q.push_back(ref_model(k, sa[idx], sb[idx], sc[idx], ss[idx], sm[idx], idx == 7));
        idx++;
      end
      prev_stall = out_valid[k] && !out_ready[k];
      h_re = out_re[k]; h_im = out_im[k]; h_last = out_last[k];
      @(posedge clk); @(negedge clk);
      cycles++;
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b1; in_last = 1'b0;
    total++;
    if (got != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL stream_count inst=%0d: got %0d outputs (%0d pending) want 8 (0 pending)",
               k, got, q.size());
    end
    total++;
    if (sat_flag[k] !== any_sat) begin
      bad++;
      $display("FAIL stream_sat_flag inst=%0d: got %b want %b", k, sat_flag[k], any_sat);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid[k] !== 1'b0) begin
        bad++;
        $display("FAIL stream_dup inst=%0d: got out_valid=%b want 0", k, out_valid[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic signed [DW-1:0] re, im;
    int lat;
    @(negedge clk);
    data_re = 16'sd1234; data_im = 16'sd77; cos_theta = 18'sd65536; sin_theta = 18'sd0;
    mode = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    in_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (out_valid[0] !== 1'b0 || out_re[0] !== 16'sd0 || sat_flag[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got valid=%b re=%0d sat=%b want 0 0 0",
               out_valid[0], out_re[0], sat_flag[0]);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0) begin
        bad++;
        $display("FAIL reset_stale: got valid0=%b valid1=%b want 0 0", out_valid[0], out_valid[1]);
      end
    end
    send_one(0, 16'sd321, -16'sd45, 18'sd65536, 18'sd0, 1'b0, re, im, lat);
    $display("txn post_reset re=%0d im=%0d lat=%0d", re, im, lat);
    total++;
    if (lat != 3 || re !== 16'sd321 || im !== -16'sd45) begin
      bad++;
      $display("FAIL reset_recover: got lat=%0d (%0d,%0d) want lat=3 (321,-45)", lat, re, im);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_identity(0, 3);
    test_identity(1, 5);
    test_mode();
    test_rounding();
    test_saturation();
    test_backpressure(0);
    test_backpressure(1);
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
